// File: rtl/alu_result_logger_if.sv
// Bundle between the ALU result side, the logger and the byte transmitter.
//   Capture side: cap_valid, in_sel, out_sel, cur_state, final1, final2, result
//   Byte side   : tx_data, tx_valid, tx_ready, tx_last
// Handshake: a byte transfers on a rising edge where tx_valid & tx_ready are
// both 1. Once tx_valid rises, tx_valid, tx_data and tx_last stay constant
// until that transfer happens (only reset may drop them). tx_ready may change
// freely and does not depend on tx_valid.
// modport slave  : the logger (consumes captures, produces bytes)
// modport master : the environment (produces captures, sinks bytes)
interface alu_result_logger_if;
  logic       cap_valid;
  logic [2:0] in_sel;
  logic [6:0] out_sel;
  logic [1:0] cur_state;
  logic [7:0] final1;
  logic [7:0] final2;
  logic [7:0] result;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport slave (
    input  cap_valid, in_sel, out_sel, cur_state, final1, final2, result,
    input  tx_ready,
    output tx_data, tx_valid, tx_last
  );

  modport master (
    output cap_valid, in_sel, out_sel, cur_state, final1, final2, result,
    output tx_ready,
    input  tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/alu_result_logger.sv
// Captures completed ALU operations into a small FIFO and streams each one as
// a 4-byte record {header, final1, final2, result} over a valid/ready byte port.
// Header: [7:5] op index (3'b111 when out_sel is not one-hot), [4:3] cur_state,
// [2:0] in_sel.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   on            logger enable (gates new captures only)
//   bus           capture fields and tx byte port (alu_result_logger_if.slave)
//   fifo_count    records queued, not counting the one being sent
//   drop_cnt      saturating count of captures lost to a full FIFO
//   busy          a record is being sent or queued
//   dbg_state_o   current FSM state
module alu_result_logger #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     on,
  alu_result_logger_if.slave       bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     busy,
  output logic [2:0]               dbg_state_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [31:0]       rec_q;
  logic [DROP_W-1:0] drop_q;

  logic [AW:0] count;
  logic        empty, full, hs, pop, cap, push, drop;
  logic [2:0]  op_idx, n_set;
  logic [7:0]  hdr;
  logic        tx_valid_s;

  // Op index of the single set out_sel bit; any other population maps to 7.
  always_comb begin
    op_idx = 3'b111;
    n_set  = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (bus.out_sel[i]) begin
        n_set  = n_set + 3'd1;
        op_idx = i[2:0];
      end
    end
    if (n_set != 3'd1) op_idx = 3'b111;
  end

  assign hdr   = {op_idx, bus.cur_state, bus.in_sel};
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign hs    = tx_valid_s & bus.tx_ready;
  // Load the tx register from IDLE, or straight from B3 on its final
  // handshake so records go out back-to-back.
  assign pop   = !empty && ((state_q == S_IDLE) || ((state_q == S_B3) && hs));
  assign cap   = on & bus.cap_valid;
  // A full FIFO still accepts a capture when a pop frees a slot on the same edge.
  assign push  = cap & (!full | pop);
  assign drop  = cap & full & !pop;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_B0;
      S_B0:    if (hs) state_d = S_B1;
      S_B1:    if (hs) state_d = S_B2;
      S_B2:    if (hs) state_d = S_B3;
      S_B3:    if (hs) state_d = empty ? S_IDLE : S_B0;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    tx_valid_s  = 1'b0;
    bus.tx_last = 1'b0;
    bus.tx_data = 8'h00;
    case (state_q)
      S_B0: begin tx_valid_s = 1'b1; bus.tx_data = rec_q[31:24]; end
      S_B1: begin tx_valid_s = 1'b1; bus.tx_data = rec_q[23:16]; end
      S_B2: begin tx_valid_s = 1'b1; bus.tx_data = rec_q[15:8];  end
      S_B3: begin tx_valid_s = 1'b1; bus.tx_data = rec_q[7:0]; bus.tx_last = 1'b1; end
      default: ;
    endcase
  end

  assign bus.tx_valid = tx_valid_s;

  // FIFO storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {hdr, bus.final1, bus.final2, bus.result};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rec_q    <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rec_q    <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  assign fifo_count  = count;
  assign drop_cnt    = drop_q;
  assign busy        = tx_valid_s | !empty;
  assign dbg_state_o = state_q;
endmodule
